// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the RV32 core.
//
// Owns the program counter, issues word requests to instruction memory, and
// buffers the returned words in an in-order queue of DEPTH entries. A
// redirect from execute reloads the PC, flushes the queue and marks every
// request still in flight as stale, so its response is dropped on arrival.
//
// Ports
//   clk             core clock, rising edge
//   rst             asynchronous active-high reset
//   imem_req_valid  fetch request valid
//   imem_req_addr   byte address of the requested word (pc_q)
//   imem_req_ready  memory accepts the request this cycle
//   imem_rsp_valid  response word valid (in request order, never stalled)
//   imem_rsp_data   returned instruction word
//   redirect_valid  single-cycle redirect pulse from execute
//   redirect_pc     redirect target, bits [1:0] ignored
//   out_valid       queue head holds an instruction for decode
//   out_instr       instruction at the queue head
//   out_pc          PC of out_instr
//   out_ready       decode accepts the head this cycle
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  input  logic            out_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   count;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [XLEN-1:0] fifo_instr [DEPTH];
  logic [XLEN-1:0] fifo_pc    [DEPTH];

  logic            pop;
  logic            push;
  logic            drop;
  logic            req_fire;
  logic [CW:0]     slots_used;
  logic [CW-1:0]   outstanding_nxt;
  logic [XLEN-1:0] redirect_tgt;

  assign out_valid = (count != '0);
  assign out_instr = fifo_instr[rd_ptr];
  assign out_pc    = fifo_pc[rd_ptr];

  assign pop  = out_valid && out_ready;
  assign drop = imem_rsp_valid && (discard != '0);
  // A response arriving with a redirect is stale: it belongs to the old path.
  assign push = imem_rsp_valid && (discard == '0) && !redirect_valid;

  // Every queue slot is either filled or reserved by an in-flight request.
  // The head leaving this cycle frees its slot, which is what lets DEPTH=2
  // stream one instruction per cycle with single-cycle memory.
  assign slots_used = {1'b0, outstanding} + {1'b0, count} - (CW+1)'(pop);

  assign imem_req_valid = !rst && !redirect_valid && (slots_used < DEPTH_W);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
  assign redirect_tgt    = {redirect_pc[XLEN-1:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        // Everything still in flight after this cycle is from the old path.
        pc_q    <= redirect_tgt;
        rsp_pc  <= redirect_tgt;
        discard <= outstanding_nxt;
        count   <= '0;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
      end else begin
        if (req_fire) begin
          pc_q <= pc_q + XLEN'(4);
        end
        if (drop) begin
          discard <= discard - CW'(1);
        end
        if (push) begin
          fifo_instr[wr_ptr] <= imem_rsp_data;
          fifo_pc[wr_ptr]    <= rsp_pc;
          wr_ptr             <= wr_ptr + AW'(1);
          rsp_pc             <= rsp_pc + XLEN'(4);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule
